// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator sequencer
package calc_pkg;

    localparam int CALC_W = 32;
    localparam logic [CALC_W-1:0] DIV0_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_ADD = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } calc_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ARM,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/calc_cycle_counter.sv
// rtl/calc_cycle_counter.sv - loadable down-counter that saturates at zero
module calc_cycle_counter #(
    parameter int W = 6
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - request/response sequencer for the add/sub, multiply and divide units
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int DIV_WAIT   = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [1:0]          i_req_op,
    input  logic [CALC_W-1:0]   i_req_a,
    input  logic [CALC_W-1:0]   i_req_b,
    output logic [CALC_W-1:0]   o_opnd_a,
    output logic [CALC_W-1:0]   o_opnd_b,
    output logic [1:0]          o_unit_select,
    output logic                o_mul_reset,
    output logic                o_mul_enable,
    input  logic [CALC_W-1:0]   i_add_result,
    input  logic                i_add_cout,
    input  logic [2*CALC_W-1:0] i_mul_product,
    input  logic [CALC_W-1:0]   i_div_quotient,
    input  logic [CALC_W-1:0]   i_div_remainder,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [CALC_W-1:0]   o_rsp_result,
    output logic [CALC_W-1:0]   o_rsp_hi,
    output logic                o_rsp_overflow,
    output logic                o_rsp_div0,
    output logic                o_busy
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_WAIT) ? MUL_CYCLES : DIV_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_WAIT - 1);

    seq_state_t         r_state;
    seq_state_t         w_next;
    calc_op_t           r_op;
    calc_op_t           w_req_op;
    logic [CALC_W-1:0]  r_opnd_a;
    logic [CALC_W-1:0]  r_opnd_b;
    logic [CALC_W-1:0]  r_rsp_result;
    logic [CALC_W-1:0]  r_rsp_hi;
    logic               r_rsp_overflow;
    logic               r_rsp_div0;
    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_value;
    logic               w_cnt_zero;
    logic               w_req_div0;

    assign w_req_op   = calc_op_t'(i_req_op);
    assign w_req_div0 = (w_req_op == OP_DIV) && (i_req_b == '0);

    calc_cycle_counter #(.W(CNT_W)) u_counter (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (w_cnt_load),
        .i_load_value (w_cnt_value),
        .o_zero       (w_cnt_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_value = MUL_LOAD;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    case (w_req_op)
                        OP_SUB, OP_ADD: w_next = ST_SETTLE;
                        OP_MUL:         w_next = ST_ARM;
                        default: begin
                            if (w_req_div0) begin
                                w_next = ST_DONE;
                            end else begin
                                w_next      = ST_WAIT;
                                w_cnt_load  = 1'b1;
                                w_cnt_value = DIV_LOAD;
                            end
                        end
                    endcase
                end
            end
            ST_SETTLE: w_next = ST_DONE;
            ST_ARM: begin
                w_next     = ST_RUN;
                w_cnt_load = 1'b1;
            end
            ST_RUN:  if (w_cnt_zero) w_next = ST_DONE;
            ST_WAIT: if (w_cnt_zero) w_next = ST_DONE;
            ST_DONE: if (i_rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Responses are captured on the edge that enters DONE so they hold through backpressure.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op           <= OP_SUB;
            r_opnd_a       <= '0;
            r_opnd_b       <= '0;
            r_rsp_result   <= '0;
            r_rsp_hi       <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_div0     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_op     <= w_req_op;
                        r_opnd_a <= i_req_a;
                        r_opnd_b <= i_req_b;
                        if (w_req_div0) begin
                            r_rsp_result   <= DIV0_RESULT;
                            r_rsp_hi       <= i_req_a;
                            r_rsp_overflow <= 1'b0;
                            r_rsp_div0     <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    r_rsp_result   <= i_add_result;
                    r_rsp_hi       <= '0;
                    r_rsp_overflow <= i_add_cout;
                    r_rsp_div0     <= 1'b0;
                end
                ST_RUN: begin
                    if (w_cnt_zero) begin
                        r_rsp_result   <= i_mul_product[CALC_W-1:0];
                        r_rsp_hi       <= i_mul_product[2*CALC_W-1:CALC_W];
                        r_rsp_overflow <= (i_mul_product[2*CALC_W-1:CALC_W] != '0);
                        r_rsp_div0     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_cnt_zero) begin
                        r_rsp_result   <= i_div_quotient;
                        r_rsp_hi       <= i_div_remainder;
                        r_rsp_overflow <= 1'b0;
                        r_rsp_div0     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready    = (r_state == ST_IDLE) && !i_reset;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_rsp_valid    = (r_state == ST_DONE);
    // Enable rises in ARM while the multiplier is still held in reset.
    assign o_mul_reset    = i_reset || (r_state != ST_RUN);
    assign o_mul_enable   = !i_reset && ((r_state == ST_ARM) || (r_state == ST_RUN));
    assign o_opnd_a       = r_opnd_a;
    assign o_opnd_b       = r_opnd_b;
    assign o_unit_select  = r_op;
    assign o_rsp_result   = r_rsp_result;
    assign o_rsp_hi       = r_rsp_hi;
    assign o_rsp_overflow = r_rsp_overflow;
    assign o_rsp_div0     = r_rsp_div0;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int MUL_CYCLES = 32;
    localparam int DIV_WAIT   = 1;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic [1:0]  i_req_op = 2'b00;
    logic [31:0] i_req_a = '0;
    logic [31:0] i_req_b = '0;
    logic        i_rsp_ready = 1'b0;
    logic        o_req_ready, o_mul_reset, o_mul_enable, o_rsp_valid;
    logic        o_rsp_overflow, o_rsp_div0, o_busy;
    logic [31:0] o_opnd_a, o_opnd_b, o_rsp_result, o_rsp_hi;
    logic [1:0]  o_unit_select;
    logic [31:0] add_result, div_quotient, div_remainder;
    logic        add_cout;
    logic [63:0] mul_product;
    logic [32:0] sum33;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calc_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_WAIT(DIV_WAIT)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
        .i_req_a(i_req_a), .i_req_b(i_req_b),
        .o_opnd_a(o_opnd_a), .o_opnd_b(o_opnd_b), .o_unit_select(o_unit_select),
        .o_mul_reset(o_mul_reset), .o_mul_enable(o_mul_enable),
        .i_add_result(add_result), .i_add_cout(add_cout), .i_mul_product(mul_product),
        .i_div_quotient(div_quotient), .i_div_remainder(div_remainder),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_result(o_rsp_result), .o_rsp_hi(o_rsp_hi),
        .o_rsp_overflow(o_rsp_overflow), .o_rsp_div0(o_rsp_div0), .o_busy(o_busy)
    );

    // Unit models: combinational adder/divider, multiplier valid only after MUL_CYCLES low-reset cycles.
    int mul_low_cycles = 0;
    assign sum33         = {1'b0, o_opnd_a} + {1'b0, o_opnd_b};
    assign add_result    = o_unit_select[0] ? sum33[31:0] : o_opnd_a - o_opnd_b;
    assign add_cout      = o_unit_select[0] ? sum33[32] : (o_opnd_a < o_opnd_b);
    assign mul_product   = (!o_mul_reset && mul_low_cycles >= MUL_CYCLES - 1)
                           ? {32'b0, o_opnd_a} * {32'b0, o_opnd_b} : 64'hBAD0_BAD0_BAD0_BAD0;
    assign div_quotient  = (o_opnd_b != 0) ? o_opnd_a / o_opnd_b : 32'hDEAD_BEEF;
    assign div_remainder = (o_opnd_b != 0) ? o_opnd_a % o_opnd_b : 32'h0BAD_F00D;

    always @(posedge clk) begin
        if (o_mul_reset) mul_low_cycles <= 0;
        else             mul_low_cycles <= mul_low_cycles + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: cycle index since acceptance against the per-op latency.
    bit          started = 0;
    bit          m_active = 0;
    bit          m_is_mul = 0;
    int          m_since = 0;
    int          m_lat = 0;
    int          m_acc_cnt = 0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0, m_hi = '0;
    logic [1:0]  m_sel = '0;
    logic        m_ovf = 1'b0, m_div0 = 1'b0;
    logic [63:0] m_p;

    always @(posedge clk) begin
        started = 1;
        if (i_reset) begin
            m_active = 0; m_since = 0; m_is_mul = 0;
            m_a = '0; m_b = '0; m_sel = '0; m_res = '0; m_hi = '0; m_ovf = 0; m_div0 = 0;
        end else if (!m_active) begin
            if (i_req_valid) begin
                m_active = 1; m_since = 1; m_acc_cnt++;
                m_a = i_req_a; m_b = i_req_b; m_sel = i_req_op;
                m_is_mul = (i_req_op == 2'b10);
                m_hi = '0; m_ovf = 0; m_div0 = 0;
                case (i_req_op)
                    2'b00: begin m_res = m_a - m_b; m_ovf = (m_a < m_b); m_lat = 2; end
                    2'b01: begin {m_ovf, m_res} = {1'b0, m_a} + {1'b0, m_b}; m_lat = 2; end
                    2'b10: begin
                        m_p = {32'b0, m_a} * {32'b0, m_b};
                        m_res = m_p[31:0]; m_hi = m_p[63:32]; m_ovf = (m_hi != 0);
                        m_lat = 2 + MUL_CYCLES;
                    end
                    default: begin
                        if (m_b != 0) begin m_res = m_a / m_b; m_hi = m_a % m_b; m_lat = 1 + DIV_WAIT; end
                        else begin m_res = 32'hFFFF_FFFF; m_hi = m_a; m_div0 = 1; m_lat = 1; end
                    end
                endcase
            end
        end else if (m_since >= m_lat && i_rsp_ready) begin
            m_active = 0;
        end else begin
            m_since++;
        end
    end

    always @(negedge clk) begin
        bit v, mrun, men;
        if (started) begin
            v    = m_active && (m_since >= m_lat);
            mrun = m_active && m_is_mul && m_since >= 2 && m_since <= MUL_CYCLES + 1;
            men  = m_active && m_is_mul && m_since >= 1 && m_since <= MUL_CYCLES + 1;
            chk("req_ready", o_req_ready, !i_reset && !m_active);
            chk("busy", o_busy, m_active);
            chk("rsp_valid", o_rsp_valid, v);
            chk("mul_reset", o_mul_reset, i_reset || !mrun);
            chk("mul_enable", o_mul_enable, !i_reset && men);
            chk("opnd_a", o_opnd_a, m_a);
            chk("opnd_b", o_opnd_b, m_b);
            chk("unit_select", o_unit_select, m_sel);
            if (v) begin
                chk("rsp_result", o_rsp_result, m_res);
                chk("rsp_hi", o_rsp_hi, m_hi);
                chk("rsp_overflow", o_rsp_overflow, m_ovf);
                chk("rsp_div0", o_rsp_div0, m_div0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_res, input logic [31:0] e_hi, input logic e_ovf,
                          input logic e_div0, input int e_lat, input int hold, input bit early,
                          input bit poke);
        int acc0, n, lat;
        acc0 = m_acc_cnt;
        i_req_valid = 1; i_req_op = op; i_req_a = a; i_req_b = b;
        n = 0;
        while (m_acc_cnt == acc0 && n < 20) begin step(); n++; end
        i_req_valid = 0;
        if (m_acc_cnt == acc0) chk("accept_timeout", 0, 1);
        if (early) i_rsp_ready = 1;
        lat = 1;
        while (!o_rsp_valid && lat < 100) begin step(); lat++; end
        chk("latency", lat, e_lat);
        chk("lit_result", o_rsp_result, e_res);
        chk("lit_hi", o_rsp_hi, e_hi);
        chk("lit_overflow", o_rsp_overflow, e_ovf);
        chk("lit_div0", o_rsp_div0, e_div0);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                i_req_valid = 1; i_req_op = 2'b01; i_req_a = 32'd9; i_req_b = 32'd9;
            end
            step();
            chk("hold_valid", o_rsp_valid, 1);
            chk("hold_req_ready", o_req_ready, 0);
            chk("hold_result", o_rsp_result, e_res);
            chk("hold_opnd_a", o_opnd_a, a);
        end
        i_req_valid = 0;
        i_rsp_ready = 1;
        step();
        i_rsp_ready = 0;
        chk("post_rsp_valid", o_rsp_valid, 0);
        chk("post_req_ready", o_req_ready, 1);
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", o_busy, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_result", o_rsp_result, 0);
        chk("rst_opnd_a", o_opnd_a, 0);
        chk("rst_mul_reset", o_mul_reset, 1);
        chk("rst_mul_enable", o_mul_enable, 0);
        chk("rst_req_ready", o_req_ready, 0);
        i_reset = 0;
        #1;
        chk("rel_req_ready", o_req_ready, 1);
        step();

        run_op(2'b01, 32'd200, 32'd100, 32'd300, 0, 0, 0, 2, 0, 0, 0);
        run_op(2'b00, 32'd75, 32'd25, 32'd50, 0, 0, 0, 2, 2, 0, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1, 0, 2, 0, 0, 0);
        run_op(2'b10, 32'd25, 32'd39, 32'd975, 0, 0, 0, 2 + MUL_CYCLES, 0, 0, 0);
        run_op(2'b10, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1, 0, 2 + MUL_CYCLES, 1, 0, 0);
        run_op(2'b11, 32'd200, 32'd40, 32'd5, 32'd0, 0, 0, 1 + DIV_WAIT, 0, 1, 0);
        run_op(2'b11, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 0, 1, 1, 0, 0, 0);
        run_op(2'b00, 32'd1000, 32'd1, 32'd999, 0, 0, 0, 2, 5, 0, 1);

        i_req_valid = 1; i_req_op = 2'b10; i_req_a = 32'd3; i_req_b = 32'd4;
        step();
        i_req_valid = 0;
        repeat (10) step();
        chk("run_mul_reset", o_mul_reset, 0);
        i_reset = 1;
        step();
        chk("abort_busy", o_busy, 0);
        chk("abort_rsp_valid", o_rsp_valid, 0);
        chk("abort_mul_reset", o_mul_reset, 1);
        chk("abort_mul_enable", o_mul_enable, 0);
        i_reset = 0;
        #1;
        chk("abort_req_ready", o_req_ready, 1);
        step();
        run_op(2'b01, 32'd5, 32'd6, 32'd11, 0, 0, 0, 2, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Request/response controller for the 32-bit arithmetic calculator datapath. It accepts one operation at a time over a valid/ready handshake and registers the operands. It drives the shared operands and `select` code into the add/subtract, serial shift-multiplier and divider units, and sequences the multiplier's reset/enable start protocol. It counts each unit's latency, then captures the result and any overflow or error flag into a held response.

## Interface
Parameters:
- `MUL_CYCLES`, 32: cycles with `mul_reset` low before `mul_product` is valid.
- `DIV_WAIT`, 1: settle cycles allowed for the divider (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  2  00 SUB, 01 ADD, 10 MUL, 11 DIV.
- `req_a`, `req_b`  in  32  operands.
- `opnd_a`, `opnd_b`  out  32  registered operands to all units.
- `unit_select`  out  2  registered op code to the adder `Flag` (bit 0) and the output mux.
- `mul_reset`, `mul_enable`  out  1  multiplier control.
- `add_result`  in  32; `add_cout`  in  1.
- `mul_product`  in  64.
- `div_quotient`, `div_remainder`  in  32.
- `rsp_valid`  out  1; `rsp_ready`  in  1.
- `rsp_result`  out  32  sum/difference, product low word, or quotient.
- `rsp_hi`  out  32  product high word or remainder; 0 for add/sub.
- `rsp_overflow`  out  1  `add_cout` for add/sub; product high word ≠0 for MUL; 0 for DIV.
- `rsp_div0`  out  1  division by zero.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, SETTLE, ARM, RUN, WAIT, DONE.
- IDLE:
  - `req_ready`=1, `mul_reset`=1, `mul_enable`=0.
  - On `req_valid`: latch `req_a`/`req_b`/`req_op` into `opnd_*`/`unit_select`.
  - Next state: SUB/ADD → SETTLE; MUL → ARM; DIV with `req_b`≠0 → WAIT; DIV with `req_b`=0 → DONE.
- SETTLE (1 cycle): capture `add_result` and `add_cout`, then go to DONE.
- ARM (1 cycle): `mul_reset`=1, `mul_enable`=1. This satisfies the rule that enable rises while reset is still high.
- RUN: `mul_reset`=0, `mul_enable`=1.
  - Counter loads `MUL_CYCLES-1` on entry and decrements each cycle.
  - At count 0, capture `mul_product`, then go to DONE.
- WAIT: counter loads `DIV_WAIT-1`. At 0, capture quotient and remainder, then go to DONE.
- Divide by zero: result is `32'hFFFF_FFFF`, `rsp_hi` = `opnd_a`, `rsp_div0`=1. The divider output is ignored.
- DONE:
  - `rsp_valid`=1; all `rsp_*` outputs held stable.
  - `mul_reset`=1, `mul_enable`=0.
  - On `rsp_ready`, go to IDLE.
- Multiplication is unsigned; overflow means the product does not fit in 32 bits.
- `req_ready`=0 in every state except IDLE. Requests presented then are not accepted and must be held by the requester.

## Timing
- Reset values:
  - State IDLE, `rsp_valid`=0, `busy`=0.
  - All `rsp_*`, `opnd_*`, `unit_select` = 0.
  - `mul_reset`=1, `mul_enable`=0.
  - `req_ready`=0 while `reset` is high, and 1 from the first cycle after reset is released.
- Latency, with the request accepted at edge T:
  - ADD/SUB: `rsp_valid` from cycle T+2.
  - MUL: T+2+`MUL_CYCLES`.
  - DIV: T+1+`DIV_WAIT`.
  - DIV by zero: T+1.
- Response handshake completes on the edge where `rsp_valid`&`rsp_ready`. `req_ready` rises in the next cycle; there is no same-cycle turnaround.
- `rsp_ready` high before `rsp_valid` has no effect.
- Reset mid-operation aborts immediately: the response is lost and the multiplier is re-held in reset.
- Counter saturates at 0; `MUL_CYCLES`/`DIV_WAIT` of 1 are legal.

## Structure
- Shared package `calc_pkg`:
  - `calc_op_t` enum (OP_SUB, OP_ADD, OP_MUL, OP_DIV) with the 2-bit encoding above.
  - `seq_state_t` enum.
  - `CALC_W`=32.
  - `DIV0_RESULT`.
- The output mux in the calculator top level uses `calc_op_t`.
- Sub-module `calc_cycle_counter`: loadable down-counter with `load`, `load_value`, `zero` output; width `$clog2(MUL_CYCLES+1)`.

## Test plan
- ADD a=200, b=100 → `rsp_result`=300, `rsp_overflow`=0, `rsp_valid` at T+2. SUB a=75, b=25 → 50.
- ADD a=`32'hFFFF_FFFF`, b=1 with model `add_cout`=1 → `rsp_result`=0, `rsp_overflow`=1.
- MUL a=25, b=39 → `rsp_result`=975, `rsp_hi`=0, valid at T+34. Check ARM shows `mul_reset`=1/`mul_enable`=1 for exactly one cycle, then 32 cycles of `mul_reset`=0.
- MUL a=`32'h0001_0000`, b=`32'h0001_0000` → `rsp_result`=0, `rsp_hi`=1, `rsp_overflow`=1.
- DIV a=200, b=40 → quotient 5, `rsp_hi`=0. DIV a=7, b=0 → `rsp_result`=`32'hFFFF_FFFF`, `rsp_hi`=7, `rsp_div0`=1, valid at T+1.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 5 cycles → outputs stable, `req_ready`=0, a second request is not accepted.
  - Assert `reset` during RUN → next cycle IDLE, `rsp_valid`=0, `mul_reset`=1.
